// File: rtl/buzzer_scheduler.sv
// Fixed-priority scheduler that lets three requesters share one buzzer pin.
// Each grant plays N ON/OFF beeps on a tick timebase, then holds a cooldown gap.
module buzzer_scheduler #(
  parameter int unsigned TICK_CYCLES = 2500000,
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned OFF_TICKS   = 4,
  parameter int unsigned GAP_TICKS   = 10,
  parameter int unsigned BEEPS_0     = 5,
  parameter int unsigned BEEPS_1     = 3,
  parameter int unsigned BEEPS_2     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] req,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done,
  output logic [2:0] pending
);

  localparam int unsigned TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned PMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PMAX  = (PMAX0 > GAP_TICKS) ? PMAX0 : GAP_TICKS;
  localparam int unsigned PW    = $clog2(PMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    req_q, req_d;
  logic [2:0]    pending_q, pending_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [3:0]    beep_cnt_q, beep_cnt_d;
  logic          buzzer_q, buzzer_d;
  logic          busy_q, busy_d;
  logic [1:0]    active_id_q, active_id_d;
  logic          done_q, done_d;

  logic [2:0]    req_edge;
  logic [2:0]    grant_mask;
  logic [1:0]    grant_id;
  logic          tick;

  function automatic logic [3:0] beeps_for(input logic [1:0] id);
    case (id)
      2'd0:    return 4'(BEEPS_0);
      2'd1:    return 4'(BEEPS_1);
      default: return 4'(BEEPS_2);
    endcase
  endfunction

  always_comb begin
    req_edge    = req & ~req_q;
    tick        = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    grant_mask  = 3'b000;
    grant_id    = 2'd0;

    state_d     = state_q;
    req_d       = req;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    phase_cnt_d = phase_cnt_q;
    beep_cnt_d  = beep_cnt_q;
    buzzer_d    = buzzer_q;
    busy_d      = busy_q;
    active_id_d = active_id_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_cnt_d  = '0;
        phase_cnt_d = '0;
        buzzer_d    = 1'b0;
        busy_d      = 1'b0;
        active_id_d = 2'd0;
        if (enable && (|pending_q)) begin
          if (pending_q[0])      grant_id = 2'd0;
          else if (pending_q[1]) grant_id = 2'd1;
          else                   grant_id = 2'd2;
          grant_mask  = 3'b001 << grant_id;
          beep_cnt_d  = beeps_for(grant_id);
          active_id_d = grant_id;
          buzzer_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ON;
        end
      end
      S_ON: begin
        if (tick) begin
          if (phase_cnt_q == PW'(ON_TICKS - 1)) begin
            phase_cnt_d = '0;
            beep_cnt_d  = beep_cnt_q - 4'd1;
            buzzer_d    = 1'b0;
            if (beep_cnt_q == 4'd1) begin
              done_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              state_d = S_OFF;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + PW'(1);
          end
        end
      end
      S_OFF: begin
        if (tick) begin
          if (phase_cnt_q == PW'(OFF_TICKS - 1)) begin
            phase_cnt_d = '0;
            buzzer_d    = 1'b1;
            state_d     = S_ON;
          end else begin
            phase_cnt_d = phase_cnt_q + PW'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (phase_cnt_q == PW'(GAP_TICKS - 1)) begin
            phase_cnt_d = '0;
            busy_d      = 1'b0;
            active_id_d = 2'd0;
            state_d     = S_IDLE;
          end else begin
            phase_cnt_d = phase_cnt_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable abandons the current play outright; the aborted id is not re-queued.
    if ((state_q != S_IDLE) && !enable) begin
      state_d     = S_IDLE;
      tick_cnt_d  = '0;
      phase_cnt_d = '0;
      beep_cnt_d  = 4'd0;
      buzzer_d    = 1'b0;
      busy_d      = 1'b0;
      active_id_d = 2'd0;
      done_d      = 1'b0;
    end

    // A fresh edge in the grant cycle outranks the clear, so the id replays later.
    pending_d = (pending_q & ~grant_mask) | req_edge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= 3'b000;
      pending_q   <= 3'b000;
      tick_cnt_q  <= '0;
      phase_cnt_q <= '0;
      beep_cnt_q  <= 4'd0;
      buzzer_q    <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
      buzzer_q    <= buzzer_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
      done_q      <= done_d;
    end
  end

  assign buzzer    = buzzer_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;
  assign done      = done_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with a short tick so whole plays fit in a few dozen cycles.
module tb_buzzer_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] req;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;
  logic [2:0] pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] rq;
    int         cyc;
    logic       bz;
    logic       bsy;
    logic [1:0] id;
    logic       dn;
    logic [2:0] pend;
  } vec_t;

  vec_t       vq[$];
  logic [1:0] exp_q[$];

  buzzer_scheduler #(
    .TICK_CYCLES(4),
    .ON_TICKS   (2),
    .OFF_TICKS  (1),
    .GAP_TICKS  (3),
    .BEEPS_0    (2),
    .BEEPS_1    (3),
    .BEEPS_2    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .req      (req),
    .buzzer   (buzzer),
    .busy     (busy),
    .active_id(active_id),
    .done     (done),
    .pending  (pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic bz, input logic bsy,
                            input logic [1:0] id, input logic dn, input logic [2:0] pend);
    check({name, ".buzzer"},    32'(buzzer),    32'(bz));
    check({name, ".busy"},      32'(busy),      32'(bsy));
    check({name, ".active_id"}, 32'(active_id), 32'(id));
    check({name, ".done"},      32'(done),      32'(dn));
    check({name, ".pending"},   32'(pending),   32'(pend));
  endtask

  task automatic add_vec(input string name, input logic en, input logic [2:0] rq, input int cyc,
                         input logic bz, input logic bsy, input logic [1:0] id,
                         input logic dn, input logic [2:0] pend);
    vec_t v;
    v.name = name; v.en = en; v.rq = rq; v.cyc = cyc;
    v.bz = bz; v.bsy = bsy; v.id = id; v.dn = dn; v.pend = pend;
    vq.push_back(v);
  endtask

  initial begin
    int mism, done_cnt, done_idx, rises, pend_nz, quiet_bad;
    logic prev_bz;
    logic [1:0] e;

    rst = 1'b0; enable = 1'b1; req = 3'b000;
    step(3);
    check_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    rst = 1'b1;
    step(2);
    check_outs("idle_after_reset", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);

    // single beep of id 2, then simultaneous id1/id2 requests served in priority order
    add_vec("t1_pend",      1'b1, 3'b100,  1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b100);
    add_vec("t1_grant",     1'b1, 3'b000,  1, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    add_vec("t1_on_last",   1'b1, 3'b000,  7, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    add_vec("t1_done",      1'b1, 3'b000,  1, 1'b0, 1'b1, 2'd2, 1'b1, 3'b000);
    add_vec("t1_gap",       1'b1, 3'b000,  1, 1'b0, 1'b1, 2'd2, 1'b0, 3'b000);
    add_vec("t1_gap_last",  1'b1, 3'b000, 10, 1'b0, 1'b1, 2'd2, 1'b0, 3'b000);
    add_vec("t1_idle",      1'b1, 3'b000,  1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    add_vec("t3_pend",      1'b1, 3'b110,  1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b110);
    add_vec("t3_grant1",    1'b1, 3'b000,  1, 1'b1, 1'b1, 2'd1, 1'b0, 3'b100);
    add_vec("t3_on3_last",  1'b1, 3'b000, 31, 1'b1, 1'b1, 2'd1, 1'b0, 3'b100);
    add_vec("t3_done1",     1'b1, 3'b000,  1, 1'b0, 1'b1, 2'd1, 1'b1, 3'b100);
    add_vec("t3_idle_gap",  1'b1, 3'b000, 12, 1'b0, 1'b0, 2'd0, 1'b0, 3'b100);
    add_vec("t3_grant2",    1'b1, 3'b000,  1, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    add_vec("t3_end",       1'b1, 3'b000, 20, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);

    foreach (vq[k]) begin
      enable = vq[k].en;
      req    = vq[k].rq;
      step(vq[k].cyc);
      check_outs(vq[k].name, vq[k].bz, vq[k].bsy, vq[k].id, vq[k].dn, vq[k].pend);
    end

    // t2: three-beep pattern, cycle index 0 is the first cycle after the grant
    for (int i = 0; i < 50; i++) begin
      logic b;
      b = (i < 8) || (i >= 12 && i < 20) || (i >= 24 && i < 32);
      exp_q.push_back({b, (i < 44) ? 1'b1 : 1'b0});
    end
    req = 3'b010; step(1);
    req = 3'b000; step(1);
    check("t2_active_id", 32'(active_id), 32'd1);
    mism = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < 50; i++) begin
      e = exp_q.pop_front();
      if ({buzzer, busy} !== e) mism++;
      if (done === 1'b1) begin done_cnt++; done_idx = i; end
      step(1);
    end
    check("t2_pattern_bad_cycles", 32'(mism), 32'd0);
    check("t2_done_count", 32'(done_cnt), 32'd1);
    check("t2_done_index", 32'(done_idx), 32'd32);

    // t4: held request yields exactly one play
    req = 3'b001;
    rises = 0; done_cnt = 0; pend_nz = 0; prev_bz = buzzer;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (i == 0) check("t4_pend", 32'(pending), 32'b001);
      if (i >= 1 && pending !== 3'b000) pend_nz++;
      if (buzzer === 1'b1 && prev_bz === 1'b0) rises++;
      if (done === 1'b1) done_cnt++;
      prev_bz = buzzer;
    end
    req = 3'b000;
    check("t4_beeps", 32'(rises), 32'd2);
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_pending_after_grant", 32'(pend_nz), 32'd0);
    step(3);
    check_outs("t4_idle", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);

    // t5: abort during 2nd ON of id 1 while id 2 is queued
    req = 3'b010; step(1);
    req = 3'b000; step(1);
    req = 3'b100; step(1);
    req = 3'b000;
    check("t5_queued", 32'(pending), 32'b100);
    step(13);
    check("t5_second_on", 32'(buzzer), 32'd1);
    enable = 1'b0; step(1);
    check_outs("t5_abort", 1'b0, 1'b0, 2'd0, 1'b0, 3'b100);
    quiet_bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (buzzer !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pending !== 3'b100) quiet_bad++;
    end
    check("t5_disabled_quiet", 32'(quiet_bad), 32'd0);
    enable = 1'b1; step(1);
    check_outs("t5_resume", 1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    step(20);
    check_outs("t5_end", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);

    // t6: async reset mid-OFF with id 0 queued
    req = 3'b010; step(1);
    req = 3'b000; step(1);
    req = 3'b001; step(1);
    req = 3'b000; step(8);
    check_outs("t6_in_off", 1'b0, 1'b1, 2'd1, 1'b0, 3'b001);
    #2 rst = 1'b0;
    #1 check_outs("t6_async_reset", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step(2);
    rst = 1'b1;
    step(10);
    check_outs("t6_stays_idle", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);

    // req already high at reset release counts as one edge
    rst = 1'b0; req = 3'b100; step(1);
    rst = 1'b1; step(1);
    check("t7_pend", 32'(pending), 32'b100);
    step(1);
    check_outs("t7_grant", 1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    step(25);
    check_outs("t7_held_no_replay", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
